// File: rtl/wb_result_arbiter_pkg.sv
// wb_result_arbiter_pkg: shared widths, grant-reason enum and pointer helper
// for the writeback result arbiter. Optional feature macro used by the
// arbiter: WB_ARB_HEAD_PRIO_EN (grant the ROB head entry first).

`ifndef ROB_ID_SIZE
`define ROB_ID_SIZE 6
`endif
`ifndef DEST_ADDR_SIZE
`define DEST_ADDR_SIZE 5
`endif
`ifndef INS_TYPE_SIZE
`define INS_TYPE_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef EXCEPTION_ID_SIZE
`define EXCEPTION_ID_SIZE 4
`endif

package wb_result_arbiter_pkg;

  localparam int WB_ARB_NUM_SRC_DFLT = 3;

  // Why a source won this cycle's grant.
  typedef enum logic [1:0] {
    PICK_NONE = 2'd0,
    PICK_RR   = 2'd1,
    PICK_HEAD = 2'd2
  } pick_src_e;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_result_arbiter_rr_priority_picker.sv
// rr_priority_picker: purely combinational round-robin pick. Returns the
// first eligible index searching upward from start_ptr with wrap-around.

module rr_priority_picker #(
  parameter int NUM_SRC = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [PTR_W-1:0]   start_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand;

  // Walk the ring starting at start_ptr; the first eligible slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(start_ptr) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!grant_any && eligible[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: one-entry holding buffer per execution unit, a
// round-robin scheduler and a registered result port toward writeback.
// Build option: define WB_ARB_HEAD_PRIO_EN to grant an eligible entry whose
// ROB id equals head_id ahead of round-robin order (lowest index on ties).

module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int NUM_SRC           = WB_ARB_NUM_SRC_DFLT,
  parameter int ROB_ID_SIZE       = `ROB_ID_SIZE,
  parameter int DEST_ADDR_SIZE    = `DEST_ADDR_SIZE,
  parameter int INS_TYPE_SIZE     = `INS_TYPE_SIZE,
  parameter int DATA_WIDTH        = `DATA_WIDTH,
  parameter int EXCEPTION_ID_SIZE = `EXCEPTION_ID_SIZE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SRC-1:0]                    src_valid,
  output logic [NUM_SRC-1:0]                    src_ready,
  input  logic [NUM_SRC*ROB_ID_SIZE-1:0]        src_rob_id,
  input  logic [NUM_SRC*DEST_ADDR_SIZE-1:0]     src_dest_addr,
  input  logic [NUM_SRC*INS_TYPE_SIZE-1:0]      src_ins_type,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]         src_data,
  input  logic [NUM_SRC*EXCEPTION_ID_SIZE-1:0]  src_exception,
  input  logic [ROB_ID_SIZE-1:0]                head_id,
  input  logic                                  halt,
  output logic [ROB_ID_SIZE-1:0]                ins_rob_id,
  output logic [DEST_ADDR_SIZE-1:0]             dest_addr,
  output logic [INS_TYPE_SIZE-1:0]              ins_type,
  output logic [DATA_WIDTH-1:0]                 ins_data,
  output logic [EXCEPTION_ID_SIZE-1:0]          ins_exception,
  output logic                                  is_nop,
  output logic [NUM_SRC-1:0]                    grant_vec
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Holding buffers
  logic [NUM_SRC-1:0]           hold_valid_q, hold_valid_d;
  logic [ROB_ID_SIZE-1:0]       hold_rob_q   [NUM_SRC];
  logic [ROB_ID_SIZE-1:0]       hold_rob_d   [NUM_SRC];
  logic [DEST_ADDR_SIZE-1:0]    hold_dest_q  [NUM_SRC];
  logic [DEST_ADDR_SIZE-1:0]    hold_dest_d  [NUM_SRC];
  logic [INS_TYPE_SIZE-1:0]     hold_type_q  [NUM_SRC];
  logic [INS_TYPE_SIZE-1:0]     hold_type_d  [NUM_SRC];
  logic [DATA_WIDTH-1:0]        hold_data_q  [NUM_SRC];
  logic [DATA_WIDTH-1:0]        hold_data_d  [NUM_SRC];
  logic [EXCEPTION_ID_SIZE-1:0] hold_exc_q   [NUM_SRC];
  logic [EXCEPTION_ID_SIZE-1:0] hold_exc_d   [NUM_SRC];

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

  // Output stage
  logic [ROB_ID_SIZE-1:0]       out_rob_q, out_rob_d;
  logic [DEST_ADDR_SIZE-1:0]    out_dest_q, out_dest_d;
  logic [INS_TYPE_SIZE-1:0]     out_type_q, out_type_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [EXCEPTION_ID_SIZE-1:0] out_exc_q, out_exc_d;
  logic                         is_nop_q, is_nop_d;
  logic [NUM_SRC-1:0]           grant_vec_q, grant_vec_d;

  // Arbitration
  logic [NUM_SRC-1:0]           eligible;
  logic [NUM_SRC-1:0]           rr_grant;
  logic [PTR_W-1:0]             rr_idx;
  logic                         rr_any;
  logic [NUM_SRC-1:0]           grant;
  logic [PTR_W-1:0]             grant_idx;
  logic                         grant_any;
  pick_src_e                    pick_kind;

  assign eligible  = hold_valid_q & {NUM_SRC{~halt}};
  assign src_ready = ~hold_valid_q | grant;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible  (eligible),
    .start_ptr (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

`ifdef WB_ARB_HEAD_PRIO_EN
  logic [NUM_SRC-1:0] head_grant;
  logic [PTR_W-1:0]   head_idx;
  logic               head_any;

  // Lowest-index eligible entry that matches the ROB head.
  always_comb begin
    head_grant = '0;
    head_idx   = '0;
    head_any   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!head_any && eligible[i] && (hold_rob_q[i] == head_id)) begin
        head_any      = 1'b1;
        head_grant[i] = 1'b1;
        head_idx      = PTR_W'(i);
      end
    end
  end
`else
  logic unused_head_id;
  assign unused_head_id = ^head_id;
`endif

  // Final grant: head match overrides round-robin when enabled.
  always_comb begin
    grant     = rr_grant;
    grant_idx = rr_idx;
    pick_kind = rr_any ? PICK_RR : PICK_NONE;
`ifdef WB_ARB_HEAD_PRIO_EN
    if (head_any) begin
      grant     = head_grant;
      grant_idx = head_idx;
      pick_kind = PICK_HEAD;
    end
`endif
    grant_any = (pick_kind != PICK_NONE);
  end

  // Next-state: buffer load/clear, pointer advance, output stage load.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rob_d   = hold_rob_q;
    hold_dest_d  = hold_dest_q;
    hold_type_d  = hold_type_q;
    hold_data_d  = hold_data_q;
    hold_exc_d   = hold_exc_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_rob_d[i]   = src_rob_id[i*ROB_ID_SIZE +: ROB_ID_SIZE];
        hold_dest_d[i]  = src_dest_addr[i*DEST_ADDR_SIZE +: DEST_ADDR_SIZE];
        hold_type_d[i]  = src_ins_type[i*INS_TYPE_SIZE +: INS_TYPE_SIZE];
        hold_data_d[i]  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        hold_exc_d[i]   = src_exception[i*EXCEPTION_ID_SIZE +: EXCEPTION_ID_SIZE];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = PTR_W'(rr_next(int'(grant_idx), NUM_SRC));

    // Payload is held on idle cycles; only is_nop tells WB it is stale.
    out_rob_d   = out_rob_q;
    out_dest_d  = out_dest_q;
    out_type_d  = out_type_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;
    is_nop_d    = ~grant_any;
    grant_vec_d = grant;
    if (grant_any) begin
      out_rob_d  = hold_rob_q[grant_idx];
      out_dest_d = hold_dest_q[grant_idx];
      out_type_d = hold_type_q[grant_idx];
      out_data_d = hold_data_q[grant_idx];
      out_exc_d  = hold_exc_q[grant_idx];
    end
  end

  // State registers; reset drops any held results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_rob_q[i]  <= '0;
        hold_dest_q[i] <= '0;
        hold_type_q[i] <= '0;
        hold_data_q[i] <= '0;
        hold_exc_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      out_rob_q   <= '0;
      out_dest_q  <= '0;
      out_type_q  <= '0;
      out_data_q  <= '0;
      out_exc_q   <= '0;
      is_nop_q    <= 1'b1;
      grant_vec_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rob_q   <= hold_rob_d;
      hold_dest_q  <= hold_dest_d;
      hold_type_q  <= hold_type_d;
      hold_data_q  <= hold_data_d;
      hold_exc_q   <= hold_exc_d;
      rr_ptr_q     <= rr_ptr_d;
      out_rob_q    <= out_rob_d;
      out_dest_q   <= out_dest_d;
      out_type_q   <= out_type_d;
      out_data_q   <= out_data_d;
      out_exc_q    <= out_exc_d;
      is_nop_q     <= is_nop_d;
      grant_vec_q  <= grant_vec_d;
    end
  end

  assign ins_rob_id    = out_rob_q;
  assign dest_addr     = out_dest_q;
  assign ins_type      = out_type_q;
  assign ins_data      = out_data_q;
  assign ins_exception = out_exc_q;
  assign is_nop        = is_nop_q;
  assign grant_vec     = grant_vec_q;

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Bench for wb_result_arbiter: directed scenarios plus a randomized run,
// all compared against a queue-free per-source slot model of the arbiter.

module tb_wb_result_arbiter;

   localparam int N  = 3;
   localparam int RW = 6;
   localparam int AW = 5;
   localparam int TW = 4;
   localparam int DW = 32;
   localparam int EW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*RW-1:0] src_rob_id;
   logic [N*AW-1:0] src_dest_addr;
   logic [N*TW-1:0] src_ins_type;
   logic [N*DW-1:0] src_data;
   logic [N*EW-1:0] src_exception;
   logic [RW-1:0]   head_id;
   logic            halt;
   logic [RW-1:0]   ins_rob_id;
   logic [AW-1:0]   dest_addr;
   logic [TW-1:0]   ins_type;
   logic [DW-1:0]   ins_data;
   logic [EW-1:0]   ins_exception;
   logic            is_nop;
   logic [N-1:0]    grant_vec;

   always #5 clk = ~clk;

   wb_result_arbiter #(
      .NUM_SRC(N), .ROB_ID_SIZE(RW), .DEST_ADDR_SIZE(AW),
      .INS_TYPE_SIZE(TW), .DATA_WIDTH(DW), .EXCEPTION_ID_SIZE(EW)
   ) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_rob_id(src_rob_id), .src_dest_addr(src_dest_addr),
      .src_ins_type(src_ins_type), .src_data(src_data),
      .src_exception(src_exception), .head_id(head_id), .halt(halt),
      .ins_rob_id(ins_rob_id), .dest_addr(dest_addr), .ins_type(ins_type),
      .ins_data(ins_data), .ins_exception(ins_exception),
      .is_nop(is_nop), .grant_vec(grant_vec)
   );

   int errors = 0;
   int checks = 0;

   logic [N-1:0]  v_in;
   logic [RW-1:0] r_in [N];
   logic [AW-1:0] a_in [N];
   logic [TW-1:0] t_in [N];
   logic [DW-1:0] d_in [N];
   logic [EW-1:0] x_in [N];
   logic          h_in;
   logic [RW-1:0] hd_in;

   bit            mv   [N];
   logic [RW-1:0] mrob [N];
   logic [AW-1:0] mdst [N];
   logic [TW-1:0] mtyp [N];
   logic [DW-1:0] mdat [N];
   logic [EW-1:0] mexc [N];
   int            mrr;
   int            e_g;
   logic [N-1:0]  e_ready;
   bit            e_nop;
   logic [N-1:0]  e_gv;
   logic [RW-1:0] e_rob;
   logic [AW-1:0] e_dst;
   logic [TW-1:0] e_typ;
   logic [DW-1:0] e_dat;
   logic [EW-1:0] e_exc;

   task automatic mreset();
      for (int i = 0; i < N; i++) mv[i] = 0;
      mrr = 0; e_nop = 1; e_gv = '0;
      e_rob = '0; e_dst = '0; e_typ = '0; e_dat = '0; e_exc = '0;
   endtask

   task automatic idle();
      v_in = '0; h_in = 1'b0;
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         src_rob_id[i*RW +: RW]    = r_in[i];
         src_dest_addr[i*AW +: AW] = a_in[i];
         src_ins_type[i*TW +: TW]  = t_in[i];
         src_data[i*DW +: DW]      = d_in[i];
         src_exception[i*EW +: EW] = x_in[i];
      end
      src_valid = v_in; halt = h_in; head_id = hd_in;
      #1;
      e_g = -1;
      if (!h_in) begin
`ifdef WB_ARB_HEAD_PRIO_EN
         for (int i = 0; i < N; i++)
            if (e_g < 0 && mv[i] && mrob[i] == hd_in) e_g = i;
`endif
         for (int k = 0; k < N; k++)
            if (e_g < 0 && mv[(mrr + k) % N]) e_g = (mrr + k) % N;
      end
      for (int i = 0; i < N; i++) e_ready[i] = !mv[i] || (e_g == i);
   endtask

   task automatic advance();
      if (e_g >= 0) begin
         e_nop = 0; e_gv = '0; e_gv[e_g] = 1'b1;
         e_rob = mrob[e_g]; e_dst = mdst[e_g]; e_typ = mtyp[e_g];
         e_dat = mdat[e_g]; e_exc = mexc[e_g];
         mrr = (e_g + 1) % N;
         mv[e_g] = 0;
      end else begin
         e_nop = 1; e_gv = '0;
      end
      for (int i = 0; i < N; i++)
         if (v_in[i] && e_ready[i]) begin
            mv[i] = 1; mrob[i] = r_in[i]; mdst[i] = a_in[i]; mtyp[i] = t_in[i];
            mdat[i] = d_in[i]; mexc[i] = x_in[i];
         end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; idle(); apply();
      @(negedge clk);
      reset = 1'b0; mreset();
   endtask

   task automatic test_reset();
      checks++;
      if ({is_nop, grant_vec, src_ready, ins_data, ins_exception} !== {1'b1, 3'b000, 3'b111, 32'h0, 4'h0}) begin
         errors++;
         $display("FAIL reset_por: got nop=%0b gv=%b rdy=%b data=%0h exc=%0h want 1 000 111 0 0",
                  is_nop, grant_vec, src_ready, ins_data, ins_exception);
      end
      do_reset();
      v_in = 3'b011; r_in[0] = 6'd1; r_in[1] = 6'd2; d_in[0] = 32'h11; d_in[1] = 32'h22;
      apply(); advance();
      idle(); apply(); advance();
      checks++;
      if (is_nop !== 1'b0 || ins_data !== 32'h11) begin
         errors++;
         $display("FAIL reset_preload: got nop=%0b data=%0h want 0 11", is_nop, ins_data);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++;
      if (is_nop !== 1'b1) begin
         errors++;
         $display("FAIL reset_async_nop: got %0b want 1", is_nop);
      end
      checks++;
      if (grant_vec !== 3'b000) begin
         errors++;
         $display("FAIL reset_async_gv: got %b want 000", grant_vec);
      end
      checks++;
      if (src_ready !== 3'b111) begin
         errors++;
         $display("FAIL reset_async_ready: got %b want 111", src_ready);
      end
      checks++;
      if (ins_data !== 32'h0 || ins_rob_id !== 6'h0 || ins_exception !== 4'h0) begin
         errors++;
         $display("FAIL reset_async_payload: got data=%0h rob=%0h exc=%0h want 0", ins_data, ins_rob_id, ins_exception);
      end
      @(negedge clk);
      reset = 1'b0; mreset();
      idle(); apply(); advance();
      checks++;
      if (is_nop !== 1'b1 || grant_vec !== 3'b000) begin
         errors++;
         $display("FAIL reset_no_stale: got nop=%0b gv=%b want 1 000", is_nop, grant_vec);
      end
   endtask

   task automatic test_single();
      do_reset();
      v_in = 3'b010; r_in[1] = 6'd5; d_in[1] = 32'hA5;
      apply();
      checks++;
      if (src_ready !== 3'b111) begin
         errors++;
         $display("FAIL single_ready: got %b want 111", src_ready);
      end
      advance();
      checks++;
      if (is_nop !== 1'b1) begin
         errors++;
         $display("FAIL single_c1_nop: got %0b want 1", is_nop);
      end
      idle(); apply(); advance();
      checks++;
      if ({is_nop, grant_vec, ins_rob_id, ins_data} !== {1'b0, 3'b010, 6'd5, 32'hA5}) begin
         errors++;
         $display("FAIL single_c2: got nop=%0b gv=%b rob=%0d data=%0h want 0 010 5 a5",
                  is_nop, grant_vec, ins_rob_id, ins_data);
      end
      apply(); advance();
      checks++;
      if (is_nop !== 1'b1) begin
         errors++;
         $display("FAIL single_c3_nop: got %0b want 1", is_nop);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] want;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         v_in = 3'b111;
         for (int i = 0; i < N; i++) begin
            r_in[i] = RW'(c * 3 + i); d_in[i] = $urandom;
         end
         apply();
         checks++;
         if (src_ready !== e_ready) begin
            errors++;
            $display("FAIL contention_ready c%0d: got %b want %b", c, src_ready, e_ready);
         end
         advance();
         if (c >= 1) begin
            want = '0; want[(c - 1) % 3] = 1'b1;
            checks++;
            if (is_nop !== 1'b0 || grant_vec !== want || ins_data !== e_dat) begin
               errors++;
               $display("FAIL contention_out c%0d: got nop=%0b gv=%b data=%0h want 0 %b %0h",
                        c, is_nop, grant_vec, ins_data, want, e_dat);
            end
         end
      end
   endtask

   task automatic test_head_prio();
      logic [N-1:0] first, second;
`ifdef WB_ARB_HEAD_PRIO_EN
      first = 3'b100; second = 3'b001;
`else
      first = 3'b001; second = 3'b100;
`endif
      do_reset();
      hd_in = 6'd7;
      v_in = 3'b101; r_in[0] = 6'd3; r_in[2] = 6'd7;
      apply(); advance();
      idle(); apply(); advance();
      checks++;
      if (is_nop !== 1'b0 || grant_vec !== first) begin
         errors++;
         $display("FAIL head_first: got nop=%0b gv=%b want 0 %b", is_nop, grant_vec, first);
      end
      apply(); advance();
      checks++;
      if (is_nop !== 1'b0 || grant_vec !== second || ins_rob_id !== e_rob) begin
         errors++;
         $display("FAIL head_second: got nop=%0b gv=%b rob=%0d want 0 %b %0d",
                  is_nop, grant_vec, ins_rob_id, second, e_rob);
      end
   endtask

   task automatic test_halt();
      do_reset();
      h_in = 1'b1; v_in = 3'b011; r_in[0] = 6'd10; r_in[1] = 6'd11;
      apply(); advance();
      v_in = '0;
      for (int c = 0; c < 3; c++) begin
         apply();
         checks++;
         if (src_ready !== 3'b100) begin
            errors++;
            $display("FAIL halt_ready c%0d: got %b want 100", c, src_ready);
         end
         advance();
         checks++;
         if (is_nop !== 1'b1) begin
            errors++;
            $display("FAIL halt_nop c%0d: got %0b want 1", c, is_nop);
         end
      end
      h_in = 1'b0;
      apply(); advance();
      checks++;
      if ({is_nop, grant_vec, ins_rob_id} !== {1'b0, 3'b001, 6'd10}) begin
         errors++;
         $display("FAIL halt_release0: got nop=%0b gv=%b rob=%0d want 0 001 10", is_nop, grant_vec, ins_rob_id);
      end
      apply(); advance();
      checks++;
      if ({is_nop, grant_vec, ins_rob_id} !== {1'b0, 3'b010, 6'd11}) begin
         errors++;
         $display("FAIL halt_release1: got nop=%0b gv=%b rob=%0d want 0 010 11", is_nop, grant_vec, ins_rob_id);
      end
   endtask

   task automatic test_exception();
      do_reset();
      v_in = 3'b100; x_in[2] = 4'd2; r_in[2] = 6'd9; a_in[2] = 5'd17; t_in[2] = 4'd6; d_in[2] = 32'hDEAD_BEEF;
      apply(); advance();
      idle(); apply(); advance();
      checks++;
      if ({is_nop, ins_exception, dest_addr, ins_type, ins_data} !== {1'b0, 4'd2, 5'd17, 4'd6, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL exception_pass: got nop=%0b exc=%0d dest=%0d type=%0d data=%0h want 0 2 17 6 deadbeef",
                  is_nop, ins_exception, dest_addr, ins_type, ins_data);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         v_in = N'($urandom);
         h_in = ($urandom_range(0, 7) == 0);
         hd_in = RW'($urandom_range(0, 3));
         for (int i = 0; i < N; i++) begin
            r_in[i] = RW'($urandom_range(0, 3)); a_in[i] = AW'($urandom);
            t_in[i] = TW'($urandom); d_in[i] = $urandom; x_in[i] = EW'($urandom);
         end
         apply();
         checks++;
         if (src_ready !== e_ready) begin
            errors++;
            $display("FAIL random_ready c%0d: got %b want %b", c, src_ready, e_ready);
         end
         advance();
         checks++;
         if (is_nop !== e_nop || grant_vec !== e_gv) begin
            errors++;
            $display("FAIL random_ctrl c%0d: got nop=%0b gv=%b want %0b %b", c, is_nop, grant_vec, e_nop, e_gv);
         end
         if (!e_nop) begin
            checks++;
            if ({ins_rob_id, dest_addr, ins_type, ins_data, ins_exception} !== {e_rob, e_dst, e_typ, e_dat, e_exc}) begin
               errors++;
               $display("FAIL random_payload c%0d: got rob=%0d data=%0h exc=%0h want %0d %0h %0h",
                        c, ins_rob_id, ins_data, ins_exception, e_rob, e_dat, e_exc);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; hd_in = '0; idle();
      for (int i = 0; i < N; i++) begin
         r_in[i] = '0; a_in[i] = '0; t_in[i] = '0; d_in[i] = '0; x_in[i] = '0;
      end
      src_valid = '0; halt = 1'b0; head_id = '0;
      src_rob_id = '0; src_dest_addr = '0; src_ins_type = '0; src_data = '0; src_exception = '0;
      mreset();
      #1;
      test_reset();
      test_single();
      test_contention();
      test_head_prio();
      test_halt();
      test_exception();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
